wb_regfile: RTL

Parametrised writeback stage and architectural register file for the Y86-64 pipeline. It decodes the W-stage instruction, commits valE/valM to the register array on the clock edge and latches exception status. It serves decode's two read ports with same-cycle write bypass and provides a sequential register-dump port for the testbench. It replaces file-based register exchange with a synthesizable array.

---
 rtl/y86_pkg.sv | 55 +++++
 rtl/wb_regfile_bypass.sv | 30 +++
 rtl/wb_regfile.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, status codes, register ids and
// the writeback register-dump state encoding.
package y86_pkg;

   localparam int unsigned ICODE_W = 4;
   localparam int unsigned STAT_W  = 3;
   localparam int unsigned REG_AW  = 4;

   localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
   localparam logic [ICODE_W-1:0] INOP    = 4'h1;
   localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
   localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
   localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
   localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
   localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
   localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
   localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
   localparam logic [ICODE_W-1:0] IRET    = 4'h9;
   localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
   localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

   localparam logic [STAT_W-1:0] SBUB = 3'd0;
   localparam logic [STAT_W-1:0] SAOK = 3'd1;
   localparam logic [STAT_W-1:0] SHLT = 3'd2;
   localparam logic [STAT_W-1:0] SADR = 3'd3;
   localparam logic [STAT_W-1:0] SINS = 3'd4;

   localparam logic [REG_AW-1:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_DUMP = 2'd1,
      DS_DONE = 2'd2
   } dump_state_t;

   // Instructions whose valE lands in a register
   function automatic logic writes_val_e(input logic [ICODE_W-1:0] icode);
      case (icode)
         IRRMOVQ, IIRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: return 1'b1;
         IHALT, INOP, IRMMOVQ, IMRMOVQ, IJXX:                return 1'b0;
         default:                                           return 1'b0;
      endcase
   endfunction

   // Instructions whose valM lands in a register
   function automatic logic writes_val_m(input logic [ICODE_W-1:0] icode);
      return (icode == IMRMOVQ) || (icode == IPOPQ);
   endfunction

   // Undefined status codes behave as an invalid instruction
   function automatic logic [STAT_W-1:0] norm_stat(input logic [STAT_W-1:0] s);
      return (s > SINS) ? SINS : s;
   endfunction

endpackage

// File: rtl/wb_regfile_bypass.sv
// One decode read port: out-of-range addresses read zero, same-cycle writes
// are forwarded with valM taking priority over valE.
module wb_regfile_bypass
   import y86_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned NREG   = 15
) (
   input  logic [REG_AW-1:0] addr,
   input  logic              we_e,
   input  logic [REG_AW-1:0] dst_e,
   input  logic [DATA_W-1:0] val_e,
   input  logic              we_m,
   input  logic [REG_AW-1:0] dst_m,
   input  logic [DATA_W-1:0] val_m,
   input  logic [DATA_W-1:0] arr_data,
   output logic [DATA_W-1:0] data
);

   always_comb begin
      data = arr_data;
      if (32'(addr) >= NREG)
         data = '0;
      else if (we_m && (dst_m == addr))
         data = val_m;
      else if (we_e && (dst_e == addr))
         data = val_e;
   end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 writeback stage: commits valE/valM into the register array, latches
// the first exception, counts retired instructions and offers a register dump.
module wb_regfile
   import y86_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned NREG   = 15,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ICODE_W-1:0]  W_in_code,
   input  logic [STAT_W-1:0]   W_stat,
   input  logic [REG_AW-1:0]   W_dst_e,
   input  logic [REG_AW-1:0]   W_dst_m,
   input  logic [DATA_W-1:0]   W_val_e,
   input  logic [DATA_W-1:0]   W_val_m,
   input  logic [REG_AW-1:0]   rd_a_addr,
   input  logic [REG_AW-1:0]   rd_b_addr,
   output logic [DATA_W-1:0]   rd_a_data,
   output logic [DATA_W-1:0]   rd_b_data,
   output logic                halted,
   output logic [STAT_W-1:0]   halt_stat,
   output logic [CNT_W-1:0]    retired,
   input  logic                dump_req,
   output logic                dump_busy,
   output logic                dump_valid,
   output logic [REG_AW-1:0]   dump_idx,
   output logic [DATA_W-1:0]   dump_data
);

   localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

   logic [DATA_W-1:0] regs [NREG];
   logic [STAT_W-1:0] stat_n;
   logic              commit;
   logic              fault;
   logic              we_e;
   logic              we_m;
   logic [DATA_W-1:0] arr_a;
   logic [DATA_W-1:0] arr_b;

   assign stat_n = norm_stat(W_stat);
   assign commit = (stat_n == SAOK) && !halted;
   assign fault  = !halted && ((stat_n == SHLT) || (stat_n == SADR) || (stat_n == SINS));
   assign we_e   = commit && writes_val_e(W_in_code) && (W_dst_e != RNONE)
                   && (32'(W_dst_e) < NREG);
   assign we_m   = commit && writes_val_m(W_in_code) && (W_dst_m != RNONE)
                   && (32'(W_dst_m) < NREG);

   // Register array; on a shared destination only valM is written
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else begin
         if (we_e && !(we_m && (W_dst_m == W_dst_e)))
            regs[IDX_W'(W_dst_e)] <= W_val_e;
         if (we_m)
            regs[IDX_W'(W_dst_m)] <= W_val_m;
      end
   end

   // Sticky exception latch and retired-instruction counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         halted    <= 1'b0;
         halt_stat <= '0;
         retired   <= '0;
      end else begin
         if (fault) begin
            halted    <= 1'b1;
            halt_stat <= stat_n;
         end
         if (commit)
            retired <= retired + CNT_W'(1);
      end
   end

   assign arr_a = (32'(rd_a_addr) < NREG) ? regs[IDX_W'(rd_a_addr)] : '0;
   assign arr_b = (32'(rd_b_addr) < NREG) ? regs[IDX_W'(rd_b_addr)] : '0;

   wb_regfile_bypass #(.DATA_W(DATA_W), .NREG(NREG)) u_byp_a (
      .addr     (rd_a_addr),
      .we_e     (we_e),
      .dst_e    (W_dst_e),
      .val_e    (W_val_e),
      .we_m     (we_m),
      .dst_m    (W_dst_m),
      .val_m    (W_val_m),
      .arr_data (arr_a),
      .data     (rd_a_data)
   );

   wb_regfile_bypass #(.DATA_W(DATA_W), .NREG(NREG)) u_byp_b (
      .addr     (rd_b_addr),
      .we_e     (we_e),
      .dst_e    (W_dst_e),
      .val_e    (W_val_e),
      .we_m     (we_m),
      .dst_m    (W_dst_m),
      .val_m    (W_val_m),
      .arr_data (arr_b),
      .data     (rd_b_data)
   );

   dump_state_t       state_q;
   dump_state_t       state_d;
   logic [REG_AW-1:0] idx_q;
   logic [REG_AW-1:0] idx_d;
   logic              dump_valid_d;
   logic [REG_AW-1:0] dump_idx_d;
   logic [DATA_W-1:0] dump_data_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= DS_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         DS_IDLE: begin
            if (dump_req) begin
               state_d = DS_DUMP;
               idx_d   = '0;
            end
         end
         DS_DUMP: begin
            if (idx_q == REG_AW'(NREG - 1))
               state_d = DS_DONE;
            else
               idx_d = idx_q + REG_AW'(1);
         end
         DS_DONE: state_d = DS_IDLE;
         default: state_d = DS_IDLE;
      endcase
   end

   // Dump outputs are registered from the upcoming state, so the data is the
   // array content before any write landing on the same edge.
   always_comb begin
      dump_valid_d = 1'b0;
      dump_idx_d   = '0;
      dump_data_d  = '0;
      if (state_d == DS_DUMP) begin
         dump_valid_d = 1'b1;
         dump_idx_d   = idx_d;
         dump_data_d  = regs[IDX_W'(idx_d)];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dump_busy  <= 1'b0;
         dump_valid <= 1'b0;
         dump_idx   <= '0;
         dump_data  <= '0;
      end else begin
         dump_busy  <= dump_valid_d;
         dump_valid <= dump_valid_d;
         dump_idx   <= dump_idx_d;
         dump_data  <= dump_data_d;
      end
   end

endmodule
